// File: rtl/seg_display_arbiter_if.sv
// Requester-side bundle for seg_display_arbiter: level requests, per-requester glyph words,
// one-hot grant and busy flag.
interface seg_display_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] digits;
    logic [NREQ-1:0]    gnt;
    logic               busy;

    modport master (output req, output digits, input gnt, input busy);
    modport slave  (input req, input digits, output gnt, output busy);
endinterface

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner arbitration of the 8-digit seven-segment display with minimum hold,
// digit scanning and glyph decoding. Define SEG_DISPLAY_ARBITER_LEADZ_EN for leading-zero blanking.
module seg_display_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned SCAN_DIV    = 100_000,
    parameter int unsigned MIN_HOLD_MS = 500
) (
    input  logic                  CLK100MHZ,
    input  logic                  BTNU,
    seg_display_arbiter_if.slave  bus,
    output logic [7:0]            AN,
    output logic [7:0]            seg
);

    localparam int unsigned MS_DIV = CLK_HZ / 1000;
    localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned OWN_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HOLD_W = (MIN_HOLD_MS > 0) ? $clog2(MIN_HOLD_MS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_HOLD,
        S_OWN
    } state_t;

    state_t              state;
    logic [OWN_W-1:0]    owner;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [SCAN_W-1:0]   blank_cnt;
    logic [2:0]          an_idx;
    logic [MS_W-1:0]     ms_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                ms_tick_c;
    logic                scan_wrap_c;
    logic                blank_done_c;
    logic                any_req_c;
    logic                owner_req_c;
    logic                preempt_c;
    logic                leave_c;
    logic                hold_done_c;
    logic                suppress_c;
    logic [OWN_W-1:0]    lowest_c;
    logic [OWN_W-1:0]    disp_owner_c;
    logic [31:0]         word_c;
    logic [3:0]          nib_c;
    logic [7:0]          seg_c;
    logic [7:0]          an_c;
    logic [HOLD_W:0]     hold_nxt_c;

    function automatic logic [7:0] glyph(input logic [3:0] code);
        logic [7:0] g;
        case (code)
            4'h0:    g = 8'b1100_0000;
            4'h1:    g = 8'b1111_1001;
            4'h2:    g = 8'b1010_0100;
            4'h3:    g = 8'b1011_0000;
            4'h4:    g = 8'b1001_1001;
            4'h5:    g = 8'b1001_0010;
            4'h6:    g = 8'b1000_0010;
            4'h7:    g = 8'b1111_1000;
            4'h8:    g = 8'b1000_0000;
            4'h9:    g = 8'b1001_0000;
            4'hA:    g = 8'b1000_1000;
            4'hB:    g = 8'b1000_1001;
            4'hC:    g = 8'b1100_0111;
            4'hD:    g = 8'b1111_1001;
            4'hE:    g = 8'b1011_1111;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Arbitration decisions and the glyph for the current scan slot
    always_comb begin
        lowest_c  = '0;
        preempt_c = 1'b0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i]) lowest_c = OWN_W'(i);
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (bus.req[i] && (OWN_W'(i) < owner)) preempt_c = 1'b1;
        end

        ms_tick_c    = (ms_cnt == MS_W'(MS_DIV - 1));
        scan_wrap_c  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
        blank_done_c = (blank_cnt == SCAN_W'(SCAN_DIV - 1));
        any_req_c    = |bus.req;
        owner_req_c  = bus.req[owner];
        leave_c      = !owner_req_c || ((state == S_OWN) && preempt_c);
        hold_nxt_c   = {1'b0, hold_cnt} + (HOLD_W + 1)'(ms_tick_c);
        hold_done_c  = (hold_nxt_c >= (HOLD_W + 1)'(MIN_HOLD_MS));

        // On the grant edge the new owner's data is shown immediately
        disp_owner_c = (state == S_BLANK) ? lowest_c : owner;
        word_c       = bus.digits[32 * int'(disp_owner_c) +: 32];
        nib_c        = word_c[{an_idx, 2'b00} +: 4];
`ifdef SEG_DISPLAY_ARBITER_LEADZ_EN
        suppress_c   = (an_idx != 3'd0) && ((word_c >> {an_idx, 2'b00}) == 32'd0);
`else
        suppress_c   = 1'b0;
`endif
        seg_c        = suppress_c ? 8'hFF : glyph(nib_c);
        an_c         = ~(8'd1 << an_idx);
    end

    // Timebase, ownership FSM and registered pin drivers
    always_ff @(posedge CLK100MHZ) begin
        if (BTNU) begin
            state     <= S_IDLE;
            owner     <= '0;
            scan_cnt  <= '0;
            blank_cnt <= '0;
            an_idx    <= '0;
            ms_cnt    <= '0;
            hold_cnt  <= '0;
            bus.gnt   <= '0;
            bus.busy  <= 1'b0;
            AN        <= 8'hFF;
            seg       <= 8'hFF;
        end else begin
            if (scan_wrap_c) begin
                scan_cnt <= '0;
                an_idx   <= an_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            ms_cnt <= ms_tick_c ? '0 : ms_cnt + MS_W'(1);

            AN  <= 8'hFF;
            seg <= 8'hFF;

            case (state)
                S_IDLE: begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    if (any_req_c) begin
                        state     <= S_BLANK;
                        blank_cnt <= '0;
                    end
                end
                S_BLANK: begin
                    if (!blank_done_c) begin
                        blank_cnt <= blank_cnt + SCAN_W'(1);
                    end else if (any_req_c) begin
                        state    <= S_HOLD;
                        owner    <= lowest_c;
                        hold_cnt <= '0;
                        bus.gnt  <= NREQ'(1) << lowest_c;
                        bus.busy <= 1'b1;
                        AN       <= an_c;
                        seg      <= seg_c;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HOLD, S_OWN: begin
                    if (leave_c) begin
                        state     <= any_req_c ? S_BLANK : S_IDLE;
                        blank_cnt <= '0;
                        bus.gnt   <= '0;
                        bus.busy  <= 1'b0;
                    end else begin
                        if (state == S_HOLD) begin
                            hold_cnt <= HOLD_W'(hold_nxt_c);
                            if (hold_done_c) state <= S_OWN;
                        end
                        AN  <= an_c;
                        seg <= seg_c;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
